pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program counter and next-address logic for the 16-bit single-cycle CPU.
//  Drives ADDR into the instruction RAM (byte address; RAM indexes ADDR[7:1]) and takes back its Q word.
//  Computes sequential and PC-relative branch targets, applies stalls and detects end-of-program halt.
//  Counts retired instructions for the cycle-count monitor.
// PARAMETERS
//  ADDR_W        8      PC / byte-address width; PC arithmetic is modulo 2**ADDR_W
//  RESET_PC      8'h00  PC value loaded on reset; must be even
//  HALT_ON_ZERO  1      1: fetching 16'h0000 enters HALT; 0: 16'h0000 executes as a NOP
// PORTS
//  CLK         in   1       system clock, all state updates on posedge
//  RESET       in   1       synchronous, active-high reset
//  INSTR       in   16      instruction word from the instruction RAM for the current ADDR
//  IS_BRANCH   in   1       decoder: INSTR is a conditional branch (BEQ/BNE/BGEZ/BLTZ)
//  BR_TAKEN    in   1       datapath: branch condition true this cycle; ignored unless IS_BRANCH=1
//  STALL       in   1       hold PC this cycle; no retire
//  ADDR        out  ADDR_W  current PC; always even
//  PC_PLUS2    out  ADDR_W  ADDR+2 mod 2**ADDR_W, combinational
//  INSTR_VALID out  1       INSTR retires this cycle (state RUN, STALL=0, not halting)
//  HALTED      out  1       1 while in HALT
//  RETIRED     out  16      retired-instruction count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (RESET=1 at posedge): ADDR<=RESET_PC, RETIRED<=0, state<=SETTLE; HALTED=0, INSTR_VALID=0.
//   RESET has priority over every other input in every state, including HALT and mid-stall.
//  States: SETTLE -> RUN -> HALT.
//   SETTLE: exactly one cycle after RESET falls. Gives the RAM its load edge. PC holds, INSTR_VALID=0.
//   RUN: each cycle with STALL=0 retires INSTR and updates PC:
//    - IS_BRANCH & BR_TAKEN: ADDR <= ADDR + ({{(ADDR_W-7){off[5]}},off,1'b0}), off=INSTR[5:0].
//      Target is relative to the branch's own address, not to PC+2.
//    - otherwise: ADDR <= PC_PLUS2.
//    - STALL=1: ADDR, RETIRED and state hold; INSTR_VALID=0; BR_TAKEN ignored.
//   RUN -> HALT when HALT_ON_ZERO=1, STALL=0 and INSTR==16'h0000.
//    On that cycle INSTR_VALID=0, the PC does not advance and RETIRED does not increment.
//   HALT: absorbing until RESET. ADDR frozen at the address of the zero word; HALTED=1.
//  Latency: ADDR changes one posedge after the retiring cycle. Single-cycle CPU; no bubbles on a branch.
//  Taken branch with off=0 (branch-to-self) is legal. PC stays put and the instruction keeps retiring every cycle.
//  Wrap-around: sequential and branch arithmetic both wrap mod 2**ADDR_W (8'hFE+2 -> 8'h00; 8'h02+(-8) -> 8'hFA).
//  ADDR[0] is always 0; no input can make it odd.
//  RETIRED: +1 per INSTR_VALID cycle; holds at 16'hFFFF once reached.
//  Simultaneous STALL=1 and INSTR==0: stall wins, no halt that cycle.
// TESTING
//  1 Reset: RESET=1 for 2 cycles, then 0 -> ADDR=8'h00 for the reset and SETTLE cycles. INSTR_VALID=0 in SETTLE, 1 the next cycle.
//  2 Sequential: 5 non-branch words -> ADDR sequence 00,02,04,06,08,0A; RETIRED=5.
//  3 Backward branch: ADDR=8'h22 (word 17), INSTR[5:0]=6'b111000, IS_BRANCH=1, BR_TAKEN=1 -> next ADDR=8'h12 (word 9).
//    Same with BR_TAKEN=0 -> 8'h24.
//  4 Forward branch: ADDR=8'h3E (word 31), off=6'b010111, taken -> 8'h6C (word 54).
//  5 Stall + wrap: ADDR=8'hFE, STALL=1 for 3 cycles -> ADDR stays FE and RETIRED unchanged.
//    Then STALL=0 -> ADDR=8'h00.
//  6 Halt: run to word 64 (INSTR=16'h0000) -> HALTED=1 next cycle, ADDR=8'h80 frozen, RETIRED=64.
//    Mid-halt RESET -> ADDR=00, HALTED=0, RETIRED=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : program counter, next-address logic, halt detect and
// retired-instruction counter for the 16-bit single-cycle CPU.  Rev 1.0
// ============================================================================
module pc_fetch_unit #(
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_PC     = 8'h00,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       INSTR,
  input  logic              IS_BRANCH,
  input  logic              BR_TAKEN,
  input  logic              STALL,
  output logic [ADDR_W-1:0] ADDR,
  output logic [ADDR_W-1:0] PC_PLUS2,
  output logic              INSTR_VALID,
  output logic              HALTED,
  output logic [15:0]       RETIRED
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] PC_START = {RESET_PC[ADDR_W-1:1], 1'b0};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       retired_q, retired_d;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] br_off;
  logic              zero_word;
  logic              retire;

  assign pc_plus2  = pc_q + PC_STEP;
  // Word offset scaled to bytes; relative to the branch's own address.
  assign br_off    = {{(ADDR_W-7){INSTR[5]}}, INSTR[5:0], 1'b0};
  assign zero_word = HALT_ON_ZERO && (INSTR == 16'h0000);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    retire    = 1'b0;
    case (state_q)
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN: begin
        if (!STALL) begin
          if (zero_word) begin
            state_d = ST_HALT;
          end else begin
            retire = 1'b1;
            pc_d   = (IS_BRANCH && BR_TAKEN) ? (pc_q + br_off) : pc_plus2;
            if (retired_q != 16'hFFFF) begin
              retired_d = retired_q + 16'd1;
            end
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SETTLE;
      pc_q      <= PC_START;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign ADDR        = pc_q;
  assign PC_PLUS2    = pc_plus2;
  assign INSTR_VALID = retire && !RESET;
  assign HALTED      = (state_q == ST_HALT) && !RESET;
  assign RETIRED     = retired_q;

endmodule
`default_nettype wire
